cache_axi_arbiter: RTL and testbench
====================================

# cache_axi_arbiter

Memory-side controller that shares the single AXI3/4 master port between the instruction cache (line refills and uncached fetches) and the data cache (refills, uncached loads, dirty-line writebacks, uncached stores). It has an independent read FSM and write FSM. It arbitrates the two read requesters with fixed priority and converts cache line and word requests into AXI bursts. It blocks any read that hits the line held in the in-flight write buffer. It sits between the `icache`/`dcache` miss interfaces and the top-level AXI port.

## Interface
- `LINE_WORDS`, 4, 32-bit words per cache line; power of two, 2..16.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `i_rd_req` / `i_rd_rdy`  in / out  1  icache read request / accept.
- `i_rd_type`  in  3  3'b100 = line, else single (type[1:0] = size).
- `i_rd_addr`  in  32  byte address.
- `i_ret_valid` / `i_ret_last`  out  1  icache return word / final word.
- `i_ret_data`  out  32  returned word.
- `d_rd_req` / `d_rd_rdy` / `d_rd_type` / `d_rd_addr`  in/out/in/in  1/1/3/32  dcache read, same encoding as icache.
- `d_ret_valid` / `d_ret_last` / `d_ret_data`  out  1/1/32  dcache return.
- `d_wr_req` / `d_wr_rdy`  in / out  1  dcache write request / accept.
- `d_wr_type` / `d_wr_addr` / `d_wr_wstrb`  in  3/32/4  write encoding as reads; wstrb is used for single writes only.
- `d_wr_data`  in  32*LINE_WORDS  line data; word 0 = low bits.
- `arid` / `araddr` / `arlen` / `arsize` / `arvalid`  out  4/32/8/3/1  AXI AR.
- `arready`  in  1.
- `rdata` / `rlast` / `rvalid`  in  32/1/1  AXI R.
- `rready`  out  1.
- `awaddr` / `awlen` / `awsize` / `awvalid`  out  32/8/3/1  AXI AW.
- `awready`  in  1.
- `wdata` / `wstrb` / `wlast` / `wvalid`  out  32/4/1/1  AXI W.
- `wready` / `bvalid`  in  1.
- `bready`  out  1.
- The top level ties off the fixed AXI fields (burst = INCR, cache, prot, lock, wid/awid = 1).

## Operation
- Read FSM states: R_IDLE, R_AR, R_DATA. Write FSM states: W_IDLE, W_AW, W_DATA, W_B.
- Hazard: `wbusy` = write FSM not in W_IDLE. Hazard = `wbusy` && latched write addr[31:log2(4*LINE_WORDS)] == candidate read addr line bits.
- `d_rd_rdy` = R_IDLE && !reset && !hazard(d_rd_addr).
- `i_rd_rdy` = R_IDLE && !reset && !d_rd_req && !hazard(i_rd_addr). Dcache has strict priority; a blocked dcache request still holds the port.
- R_IDLE → R_AR on accept. The FSM latches the owner (i = 0, d = 1), addr and type.
  - Line: araddr = addr with offset bits cleared, arlen = LINE_WORDS-1, arsize = 2.
  - Single: araddr = addr, arlen = 0, arsize = {1'b0, type[1:0]}.
  - arid = owner.
- R_AR: arvalid = 1, held stable until arready, then → R_DATA.
- R_DATA: rready = 1. Each rvalid is forwarded combinationally to the owner: ret_valid = rvalid, ret_data = rdata, ret_last = rlast. On rvalid && rlast → R_IDLE.
- The non-owner's ret_valid is 0.
- `d_wr_rdy` = W_IDLE && !reset. On accept, the FSM latches addr, type, wstrb and the full line into the write buffer, then → W_AW.
  - Line: line-aligned addr, awlen = LINE_WORDS-1, awsize = 2, wstrb = 4'hF.
  - Single: exact addr, awlen = 0, awsize = {1'b0, type[1:0]}, latched wstrb, word 0 of data.
- W_AW: awvalid until awready, then → W_DATA with word counter = 0.
- W_DATA: wvalid = 1, wdata = buffer word[counter]. On wready the counter increments. wlast = (counter == awlen). On wready && wlast → W_B.
- W_B: bready = 1. On bvalid → W_IDLE. The write buffer stays valid for hazard compare until the cycle bvalid is seen.
- Read and write FSMs run concurrently; read data never bypasses from the write buffer.

## Timing
- While reset is asserted, and on its release: both FSMs are idle, counter = 0, and every output is 0, including rdy, valid, ready and the address fields.
- Accept cycle: rdy && req at a rising edge. arvalid rises the next cycle. Minimum read latency is accept → AR handshake 1 cycle → first ret_valid in the same cycle as the first rvalid.
- The earliest a new read accept can happen is the cycle after the rlast handshake, because R_IDLE is re-entered then.
- A single-word write takes at least 4 cycles from accept to W_IDLE (AW, W, B, idle).
- A hazard clears in the cycle after the bvalid handshake. A held dcache read is then accepted.
- Simultaneous d_rd_req and i_rd_req in R_IDLE: dcache wins; icache waits with no starvation guard, since the dcache has no back-to-back refills without core progress.
- Simultaneous write accept and read accept to the same line in W_IDLE: the read is accepted because the hazard uses the current state. The write's data is not yet visible to the read; the dcache guarantees it never does this.
- An asynchronous reset mid-burst aborts both FSMs immediately. The AXI slave is reset by the same signal.

## Test plan
- Icache line refill at 0x1c00_0014 → araddr 0x1c00_0010, arlen 3, arsize 2, arid 0. Four returns 0xA0..0xA3, with i_ret_last only on the fourth; d_ret_valid stays 0.
- i_rd_req and d_rd_req in the same cycle → d_rd_rdy = 1, i_rd_rdy = 0. Icache is accepted in the first R_IDLE cycle after the dcache rlast.
- Dcache writeback of line 0x0000_1000 with wready toggling 1,0,1,0 → 4 W beats carry data words 0..3 in order, wlast on beat 4, bready until bvalid, then d_wr_rdy = 1.
- Writeback of 0x2000 pending and d_rd_addr 0x2008 → d_rd_rdy = 0 until the cycle after bvalid. Meanwhile an icache read to 0x3000 is accepted.
- Uncached byte store: type 0, addr 0xbfaf_8001, wstrb 4'b0010 → awlen 0, awsize 0, awaddr 0xbfaf_8001, wstrb 0010, wlast on the first beat.
- Assert reset during R_DATA beat 2 → all outputs 0 immediately. After release, a new read is accepted with no return on the stale owner.

Source files
------------

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares one AXI master between icache/dcache read misses and dcache writes,
// with independent read/write FSMs and a read-after-pending-write line hazard block.
module cache_axi_arbiter #(
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_rd_req,
  output logic                     i_rd_rdy,
  input  logic [2:0]               i_rd_type,
  input  logic [31:0]              i_rd_addr,
  output logic                     i_ret_valid,
  output logic                     i_ret_last,
  output logic [31:0]              i_ret_data,
  input  logic                     d_rd_req,
  output logic                     d_rd_rdy,
  input  logic [2:0]               d_rd_type,
  input  logic [31:0]              d_rd_addr,
  output logic                     d_ret_valid,
  output logic                     d_ret_last,
  output logic [31:0]              d_ret_data,
  input  logic                     d_wr_req,
  output logic                     d_wr_rdy,
  input  logic [2:0]               d_wr_type,
  input  logic [31:0]              d_wr_addr,
  input  logic [3:0]               d_wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] d_wr_data,
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [31:0]              rdata,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic                     bvalid,
  output logic                     bready
);
  localparam int OFF = $clog2(LINE_WORDS) + 2;
  localparam int CW  = $clog2(LINE_WORDS);
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} w_state_t;
  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic                     r_owner;
  logic [31:0]              r_addr, w_addr, sel_addr;
  logic [7:0]               r_len, w_len;
  logic [2:0]               r_size, w_size, sel_type;
  logic [3:0]               w_strb;
  logic [32*LINE_WORDS-1:0] w_buf;
  logic [CW-1:0]            cnt;
  logic                     w_busy, d_hz, i_hz, d_acc, i_acc, r_acc, w_acc, r_line, w_line;
  // The write buffer keeps its line claimed until the B handshake completes.
  assign w_busy   = w_state != W_IDLE;
  assign d_hz     = w_busy && w_addr[31:OFF] == d_rd_addr[31:OFF];
  assign i_hz     = w_busy && w_addr[31:OFF] == i_rd_addr[31:OFF];
  assign d_rd_rdy = r_state == R_IDLE && !reset && !d_hz;
  assign i_rd_rdy = r_state == R_IDLE && !reset && !d_rd_req && !i_hz;
  assign d_wr_rdy = w_state == W_IDLE && !reset;
  assign d_acc    = d_rd_rdy && d_rd_req;
  assign i_acc    = i_rd_rdy && i_rd_req;
  assign r_acc    = d_acc || i_acc;
  assign w_acc    = d_wr_rdy && d_wr_req;
  assign sel_type = d_acc ? d_rd_type : i_rd_type;
  assign sel_addr = d_acc ? d_rd_addr : i_rd_addr;
  assign r_line   = sel_type == 3'b100;
  assign w_line   = d_wr_type == 3'b100;
  always_comb begin
    r_next = r_state;
    w_next = w_state;
    case (r_state)
      R_IDLE:  r_next = r_acc ? R_AR : R_IDLE;
      R_AR:    r_next = arready ? R_DATA : R_AR;
      default: r_next = rvalid && rlast ? R_IDLE : R_DATA;
    endcase
    case (w_state)
      W_IDLE:  w_next = w_acc ? W_AW : W_IDLE;
      W_AW:    w_next = awready ? W_DATA : W_AW;
      W_DATA:  w_next = wready && wlast ? W_B : W_DATA;
      default: w_next = bvalid ? W_IDLE : W_B;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_strb  <= '0;
      w_buf   <= '0;
      cnt     <= '0;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
      if (r_acc) begin
        r_owner <= d_acc;
        r_addr  <= r_line ? {sel_addr[31:OFF], {OFF{1'b0}}} : sel_addr;
        r_len   <= r_line ? 8'(LINE_WORDS - 1) : 8'd0;
        r_size  <= r_line ? 3'd2 : {1'b0, sel_type[1:0]};
      end
      if (w_acc) begin
        w_addr <= w_line ? {d_wr_addr[31:OFF], {OFF{1'b0}}} : d_wr_addr;
        w_len  <= w_line ? 8'(LINE_WORDS - 1) : 8'd0;
        w_size <= w_line ? 3'd2 : {1'b0, d_wr_type[1:0]};
        w_strb <= w_line ? 4'hF : d_wr_wstrb;
        w_buf  <= d_wr_data;
      end
      if (w_state == W_AW && awready)
        cnt <= '0;
      else if (w_state == W_DATA && wready)
        cnt <= cnt + 1'b1;
    end
  end
  assign arid        = {3'b000, r_owner};
  assign araddr      = r_addr;
  assign arlen       = r_len;
  assign arsize      = r_size;
  assign arvalid     = r_state == R_AR;
  assign rready      = r_state == R_DATA;
  assign i_ret_valid = rready && !r_owner && rvalid;
  assign i_ret_last  = i_ret_valid && rlast;
  assign i_ret_data  = rready && !r_owner ? rdata : 32'd0;
  assign d_ret_valid = rready && r_owner && rvalid;
  assign d_ret_last  = d_ret_valid && rlast;
  assign d_ret_data  = rready && r_owner ? rdata : 32'd0;
  assign awaddr      = w_addr;
  assign awlen       = w_len;
  assign awsize      = w_size;
  assign awvalid     = w_state == W_AW;
  assign wvalid      = w_state == W_DATA;
  assign wdata       = wvalid ? w_buf[{cnt, 5'd0} +: 32] : 32'd0;
  assign wstrb       = wvalid ? w_strb : 4'd0;
  assign wlast       = wvalid && 8'(cnt) == w_len;
  assign bready      = w_state == W_B;
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter: directed stimulus with queued expectations checked by a channel monitor.
module tb_cache_axi_arbiter;
  logic clk, reset;
  logic i_rd_req, i_rd_rdy, i_ret_valid, i_ret_last;
  logic [2:0] i_rd_type;
  logic [31:0] i_rd_addr, i_ret_data;
  logic d_rd_req, d_rd_rdy, d_ret_valid, d_ret_last;
  logic [2:0] d_rd_type;
  logic [31:0] d_rd_addr, d_ret_data;
  logic d_wr_req, d_wr_rdy;
  logic [2:0] d_wr_type;
  logic [31:0] d_wr_addr;
  logic [3:0] d_wr_wstrb;
  logic [127:0] d_wr_data;
  logic [3:0] arid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready;
  logic [202:0] outs;
  int n_chk = 0, n_fail = 0, b_delay = 0;
  logic wtog = 0;
  logic [63:0] ar_q[$], ri_q[$], rd_q[$], aw_q[$], w_q[$];
  logic [31:0] rb_q[$];

  cache_axi_arbiter #(.LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_rdy(i_rd_rdy), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_rdy(d_rd_rdy), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_rdy(d_wr_rdy), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
    .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  assign outs = {i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data, d_rd_rdy, d_ret_valid, d_ret_last,
                 d_ret_data, d_wr_rdy, arid, araddr, arlen, arsize, arvalid, rready, awaddr, awlen,
                 awsize, awvalid, wdata, wstrb, wlast, wvalid, bready};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bad(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected expected event at %0t", nm, $time);
  endtask

  task automatic chk_zero(input string nm);
    n_chk++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL %s: got outputs %h expected all zero", nm, outs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input bit is_d, input logic [31:0] a, input int len, input logic [2:0] sz,
                        input logic [31:0] base, input int nb);
    ar_q.push_back(64'({a, 8'(len), sz, 3'b000, is_d}));
    rb_q.push_back(base);
    for (int k = 0; k < nb; k++)
      if (is_d) rd_q.push_back(64'({base + 32'(k), k == len}));
      else ri_q.push_back(64'({base + 32'(k), k == len}));
  endtask

  task automatic rd_issue(input bit is_d, input logic [2:0] t, input logic [31:0] a);
    bit ok = 0;
    if (is_d) begin d_rd_req = 1; d_rd_type = t; d_rd_addr = a; end
    else begin i_rd_req = 1; i_rd_type = t; i_rd_addr = a; end
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = is_d ? d_rd_rdy : i_rd_rdy;
    end
    if (!ok) bad("rd_accept");
    tick();
    if (is_d) d_rd_req = 0; else i_rd_req = 0;
  endtask

  task automatic wr_issue(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                          input logic [127:0] d);
    bit ok = 0;
    d_wr_req = 1; d_wr_type = t; d_wr_addr = a; d_wr_wstrb = s; d_wr_data = d;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = d_wr_rdy;
    end
    if (!ok) bad("wr_accept");
    tick();
    d_wr_req = 0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = ar_q.size() == 0 && ri_q.size() == 0 && rd_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0;
    end
    if (!ok) bad("drain");
    tick();
  endtask

  task automatic wait_for(input string nm, input bit sel);
    bit ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = sel ? bvalid : d_ret_valid && d_ret_last;
    end
    if (!ok) bad(nm);
  endtask

  // AXI read slave: beat data counts up from a per-burst base value.
  initial begin : r_slave
    int rem, beat;
    logic [31:0] base;
    logic ar_hs, r_hs;
    rem = 0; beat = 0; base = 0;
    rvalid = 0; rlast = 0; rdata = 0;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs = rvalid && rready;
      tick();
      if (reset) begin
        rvalid = 0; rlast = 0; rdata = 0; rem = 0;
      end else begin
        if (r_hs) begin
          beat++;
          rvalid = beat < rem;
          rdata = base + 32'(beat);
          rlast = beat == rem - 1;
        end
        if (ar_hs) begin
          rem = int'(arlen) + 1;
          beat = 0;
          base = rb_q.size() > 0 ? rb_q.pop_front() : 32'hDEAD;
          rvalid = 1;
          rdata = base;
          rlast = rem == 1;
        end
      end
    end
  end

  initial begin : w_slave
    int bc;
    logic w_hs, wl_hs, b_hs;
    bc = -1;
    wready = 1; bvalid = 0;
    forever begin
      @(negedge clk);
      w_hs = wvalid && wready;
      wl_hs = w_hs && wlast;
      b_hs = bvalid && bready;
      tick();
      if (reset) begin
        wready = 1; bvalid = 0; bc = -1;
      end else begin
        wready = wtog ? !wready : 1'b1;
        if (b_hs) bvalid = 0;
        if (wl_hs) bc = b_delay;
        if (bc == 0) bvalid = 1;
        if (bc >= 0) bc--;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (arvalid && arready) begin
        if (ar_q.size() == 0) bad("ar_unexpected");
        else chk("ar", 64'({araddr, arlen, arsize, arid}), ar_q.pop_front());
      end
      if (i_ret_valid) begin
        if (ri_q.size() == 0) bad("i_ret_unexpected");
        else chk("i_ret", 64'({i_ret_data, i_ret_last}), ri_q.pop_front());
      end
      if (d_ret_valid) begin
        if (rd_q.size() == 0) bad("d_ret_unexpected");
        else chk("d_ret", 64'({d_ret_data, d_ret_last}), rd_q.pop_front());
      end
      if (awvalid && awready) begin
        if (aw_q.size() == 0) bad("aw_unexpected");
        else chk("aw", 64'({awaddr, awlen, awsize}), aw_q.pop_front());
      end
      if (wvalid && wready) begin
        if (w_q.size() == 0) bad("w_unexpected");
        else chk("w", 64'({wdata, wstrb, wlast}), w_q.pop_front());
      end
    end
  end

  initial begin : main
    reset = 0; arready = 1; awready = 1;
    i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
    d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
    d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;
    #1 reset = 1;
    @(negedge clk);
    chk_zero("reset_outputs");
    tick();
    reset = 0;
    // icache line refill
    exp_rd(0, 32'h1c00_0010, 3, 3'd2, 32'hA0, 4);
    rd_issue(0, 3'b100, 32'h1c00_0014);
    drain();
    // simultaneous requests: dcache wins, icache follows right after rlast
    exp_rd(1, 32'h0000_4000, 3, 3'd2, 32'hB0, 4);
    exp_rd(0, 32'h0000_5004, 0, 3'd2, 32'hC0, 1);
    d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h4000;
    i_rd_req = 1; i_rd_type = 3'b010; i_rd_addr = 32'h5004;
    @(negedge clk);
    chk("both_d_rdy", 64'(d_rd_rdy), 64'd1);
    chk("both_i_rdy", 64'(i_rd_rdy), 64'd0);
    tick();
    d_rd_req = 0;
    wait_for("d_rlast", 0);
    @(negedge clk);
    chk("i_after_rlast", 64'(i_rd_rdy), 64'd1);
    tick();
    i_rd_req = 0;
    drain();
    // line writeback with toggling wready
    wtog = 1; b_delay = 2;
    aw_q.push_back(64'({32'h1000, 8'd3, 3'd2}));
    for (int k = 0; k < 4; k++) w_q.push_back(64'({32'hD0 + 32'(k), 4'hF, k == 3}));
    wr_issue(3'b100, 32'h1000, 4'h0, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    wait_for("wb_bvalid", 1);
    chk("wb_bready", 64'(bready), 64'd1);
    @(negedge clk);
    chk("wb_wr_rdy_after_b", 64'(d_wr_rdy), 64'd1);
    tick();
    drain();
    // hazard: pending writeback to 0x2000 blocks dcache read of 0x2008
    wtog = 0; b_delay = 30;
    aw_q.push_back(64'({32'h2000, 8'd3, 3'd2}));
    for (int k = 0; k < 4; k++) w_q.push_back(64'({32'hE0 + 32'(k), 4'hF, k == 3}));
    wr_issue(3'b100, 32'h2000, 4'h0, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
    d_rd_addr = 32'h2008; d_rd_type = 3'b100; i_rd_addr = 32'h3000;
    @(negedge clk);
    chk("hz_d_blocked", 64'(d_rd_rdy), 64'd0);
    chk("hz_i_free", 64'(i_rd_rdy), 64'd1);
    exp_rd(0, 32'h3000, 0, 3'd2, 32'h30, 1);
    tick();
    rd_issue(0, 3'b010, 32'h3000);
    drain();
    exp_rd(1, 32'h2000, 3, 3'd2, 32'h40, 4);
    d_rd_req = 1;
    wait_for("hz_bvalid", 1);
    chk("hz_d_blocked_at_b", 64'(d_rd_rdy), 64'd0);
    @(negedge clk);
    chk("hz_d_clear", 64'(d_rd_rdy), 64'd1);
    tick();
    d_rd_req = 0;
    drain();
    // uncached byte store
    b_delay = 0;
    aw_q.push_back(64'({32'hbfaf_8001, 8'd0, 3'd0}));
    w_q.push_back(64'({32'h0000_AB00, 4'b0010, 1'b1}));
    wr_issue(3'b000, 32'hbfaf_8001, 4'b0010, {96'h0, 32'h0000_AB00});
    drain();
    // reset during the second beat of a dcache refill
    exp_rd(1, 32'h6000, 3, 3'd2, 32'h60, 2);
    rd_issue(1, 3'b100, 32'h6004);
    begin
      bit ok = 0;
      for (int k = 0; k < 200 && !ok; k++) begin
        @(negedge clk);
        ok = d_ret_valid && d_ret_data == 32'h61;
      end
      if (!ok) bad("beat2_wait");
    end
    #2 reset = 1;
    #1 chk_zero("midburst_reset");
    tick();
    tick();
    reset = 0;
    exp_rd(0, 32'h7000, 0, 3'd2, 32'h70, 1);
    rd_issue(0, 3'b010, 32'h7000);
    drain();
    repeat (4) tick();
    chk("ar_q_empty", 64'(ar_q.size()), 64'd0);
    chk("ret_q_empty", 64'(ri_q.size() + rd_q.size()), 64'd0);
    chk("wr_q_empty", 64'(aw_q.size() + w_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
